// File: rtl/vga_pixel_out.sv
// vga_pixel_out: pixel output stage behind the VGA timing generator.
// Reads the framebuffer, realigns sync/de with the returned pixel, drives RGB332.
//
// Ports
//   clk, rst                 pixel clock, synchronous active-high reset
//   hsync_in/vsync_in/de_in  raw strobes from the timing generator
//   addr_in                  linear pixel address, forwarded to the BRAM
//   hdata_in/vdata_in        pixel counters (low 8 bits drive the patterns)
//   mode_req                 requested source, sampled at the frame boundary
//   fb_addr/fb_rdata         framebuffer read port (RD_LAT cycles latency)
//   video_*                  registered RGB332, syncs and data enable
//   mode_cur                 source currently in effect
//   frame_count              completed frames since reset (wraps)
module vga_pixel_out #(
    parameter int         WIDTH  = 12,
    parameter int         RD_LAT = 1,
    parameter bit         HSPP   = 1'b0,
    parameter bit         VSPP   = 1'b0,
    parameter logic [7:0] SOLID  = 8'hE0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             de_in,
    input  logic [18:0]      addr_in,
    input  logic [WIDTH-1:0] hdata_in,
    input  logic [WIDTH-1:0] vdata_in,
    input  logic [1:0]       mode_req,
    output logic [18:0]      fb_addr,
    input  logic [7:0]       fb_rdata,
    output logic [2:0]       video_red,
    output logic [2:0]       video_green,
    output logic [1:0]       video_blue,
    output logic             video_hsync,
    output logic             video_vsync,
    output logic             video_de,
    output logic [1:0]       mode_cur,
    output logic [15:0]      frame_count
);

    // Delay line depth: stage A plus the BRAM read latency, so the
    // strobes leave the last tap on the same cycle fb_rdata is valid.
    localparam int DL = RD_LAT + 1;

    localparam logic HS_OFF = ~HSPP;
    localparam logic VS_OFF = ~VSPP;

    typedef enum logic [1:0] {
        MODE_FB    = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_SOLID = 2'd2,
        MODE_CHECK = 2'd3
    } mode_e;

    // ------------------------------------------------------------------
    // Stage A and strobe delay line
    // ------------------------------------------------------------------
    logic [18:0]   fb_addr_q;
    logic [18:0]   fb_addr_d;
    logic [DL-1:0] hs_q;
    logic [DL-1:0] vs_q;
    logic [DL-1:0] de_q;
    logic [7:0]    hd_q [DL];
    logic [7:0]    vd_q [DL];
    mode_e         md_q [DL];

    mode_e         mode_cur_q;

    // BRAM port stays idle in blanking: address only moves on active pixels.
    always_comb begin
        fb_addr_d = fb_addr_q;
        if (de_in) begin
            fb_addr_d = addr_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_addr_q <= '0;
            hs_q      <= {DL{HS_OFF}};
            vs_q      <= {DL{VS_OFF}};
            de_q      <= '0;
            for (int i = 0; i < DL; i++) begin
                hd_q[i] <= '0;
                vd_q[i] <= '0;
                md_q[i] <= MODE_FB;
            end
        end else begin
            fb_addr_q <= fb_addr_d;
            hs_q      <= {hs_q[DL-2:0], hsync_in};
            vs_q      <= {vs_q[DL-2:0], vsync_in};
            de_q      <= {de_q[DL-2:0], de_in};
            hd_q[0]   <= hdata_in[7:0];
            vd_q[0]   <= vdata_in[7:0];
            // Mode travels with the pixel so in-flight pixels keep
            // the source they were issued under.
            md_q[0]   <= mode_cur_q;
            for (int i = 1; i < DL; i++) begin
                hd_q[i] <= hd_q[i-1];
                vd_q[i] <= vd_q[i-1];
                md_q[i] <= md_q[i-1];
            end
        end
    end

    // Taps aligned with fb_rdata
    logic  hs_dl;
    logic  vs_dl;
    logic  de_dl;
    logic  [7:0] hd_dl;
    logic  [7:0] vd_dl;
    mode_e md_dl;

    assign hs_dl = hs_q[DL-1];
    assign vs_dl = vs_q[DL-1];
    assign de_dl = de_q[DL-1];
    assign hd_dl = hd_q[DL-1];
    assign vd_dl = vd_q[DL-1];
    assign md_dl = md_q[DL-1];

    // ------------------------------------------------------------------
    // Pixel select
    // ------------------------------------------------------------------
    logic [2:0] bar_idx;
    logic [7:0] bar_pix;
    logic [7:0] chk_pix;
    logic [7:0] pix_d;

    assign bar_idx = hd_dl[7:5];
    assign bar_pix = {{3{bar_idx[2]}}, {3{bar_idx[1]}}, {2{bar_idx[0]}}};
    assign chk_pix = (hd_dl[4] ^ vd_dl[4]) ? 8'hFF : 8'h00;

    always_comb begin
        pix_d = 8'h00;
        if (de_dl) begin
            unique case (md_dl)
                MODE_FB:    pix_d = fb_rdata;
                MODE_BARS:  pix_d = bar_pix;
                MODE_SOLID: pix_d = SOLID;
                MODE_CHECK: pix_d = chk_pix;
                default:    pix_d = 8'h00;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage C: output register
    // ------------------------------------------------------------------
    logic [7:0] pix_q;
    logic       vhs_q;
    logic       vvs_q;
    logic       vde_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q <= '0;
            vhs_q <= HS_OFF;
            vvs_q <= VS_OFF;
            vde_q <= 1'b0;
        end else begin
            pix_q <= pix_d;
            vhs_q <= hs_dl;
            vvs_q <= vs_dl;
            vde_q <= de_dl;
        end
    end

    // ------------------------------------------------------------------
    // Frame boundary: vsync inactive -> active on the raw input
    // ------------------------------------------------------------------
    logic        vs_prev_q;
    logic        vs_act;
    logic        vs_act_prev;
    logic        frame_evt;
    mode_e       mode_cur_d;
    logic [15:0] frame_count_q;
    logic [15:0] frame_count_d;

    assign vs_act      = (vsync_in == VSPP);
    assign vs_act_prev = (vs_prev_q == VSPP);
    assign frame_evt   = vs_act & ~vs_act_prev;

    always_comb begin
        mode_cur_d    = mode_cur_q;
        frame_count_d = frame_count_q;
        if (frame_evt) begin
            mode_cur_d    = mode_e'(mode_req);
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    // vs_prev_q resets inactive, so a vsync already active when reset
    // drops is taken as the first boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev_q     <= VS_OFF;
            mode_cur_q    <= MODE_FB;
            frame_count_q <= '0;
        end else begin
            vs_prev_q     <= vsync_in;
            mode_cur_q    <= mode_cur_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Upper counter bits only matter to the timing generator.
    logic unused_hv;
    assign unused_hv = ^{hdata_in, vdata_in};

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign fb_addr     = fb_addr_q;
    assign video_red   = pix_q[7:5];
    assign video_green = pix_q[4:2];
    assign video_blue  = pix_q[1:0];
    assign video_hsync = vhs_q;
    assign video_vsync = vvs_q;
    assign video_de    = vde_q;
    assign mode_cur    = mode_cur_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_pixel_out.sv
// tb_vga_pixel_out: directed bench for vga_pixel_out, RD_LAT=1 and RD_LAT=3.
// Scoreboard queues hold expected video outputs per driven cycle.
module tb_vga_pixel_out;

    localparam bit HSPP = 1'b0;
    localparam bit VSPP = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        de_in = 1'b0;
    logic [18:0] addr_in = '0;
    logic [11:0] hdata_in = '0;
    logic [11:0] vdata_in = '0;
    logic [1:0]  mode_req = '0;

    logic [18:0] fb_addr1, fb_addr3;
    logic [7:0]  rdata1, rdata3;
    logic [2:0]  red1, green1, red3, green3;
    logic [1:0]  blue1, blue3;
    logic        hs1, vs1, de1, hs3, vs3, de3;
    logic [1:0]  mode1, mode3;
    logic [15:0] fc1, fc3;

    vga_pixel_out #(.WIDTH(12), .RD_LAT(1), .HSPP(HSPP), .VSPP(VSPP), .SOLID(8'hE0)) u_d1 (
        .clk(clk), .rst(rst),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
        .addr_in(addr_in), .hdata_in(hdata_in), .vdata_in(vdata_in),
        .mode_req(mode_req), .fb_addr(fb_addr1), .fb_rdata(rdata1),
        .video_red(red1), .video_green(green1), .video_blue(blue1),
        .video_hsync(hs1), .video_vsync(vs1), .video_de(de1),
        .mode_cur(mode1), .frame_count(fc1)
    );

    vga_pixel_out #(.WIDTH(12), .RD_LAT(3), .HSPP(HSPP), .VSPP(VSPP), .SOLID(8'hE0)) u_d3 (
        .clk(clk), .rst(rst),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
        .addr_in(addr_in), .hdata_in(hdata_in), .vdata_in(vdata_in),
        .mode_req(mode_req), .fb_addr(fb_addr3), .fb_rdata(rdata3),
        .video_red(red3), .video_green(green3), .video_blue(blue3),
        .video_hsync(hs3), .video_vsync(vs3), .video_de(de3),
        .mode_cur(mode3), .frame_count(fc3)
    );

    function automatic logic [7:0] mem_f(input logic [18:0] a);
        return a[7:0] + 8'hDE;
    endfunction

    // Framebuffer models
    logic [7:0] r1 = 8'h00;
    logic [7:0] r3a = 8'h00, r3b = 8'h00, r3c = 8'h00;
    always @(posedge clk) begin
        r1  <= mem_f(fb_addr1);
        r3a <= mem_f(fb_addr3);
        r3b <= r3a;
        r3c <= r3b;
    end
    assign rdata1 = r1;
    assign rdata3 = r3c;

    typedef struct {
        int         due;
        logic       de;
        logic       hs;
        logic       vs;
        logic [7:0] rgb;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    exp_t c1, c3;

    int tests = 0;
    int fails = 0;
    int edge_n = 0;

    logic [1:0]  m_mode = 2'd0;
    logic [15:0] m_fc = 16'd0;
    logic        m_vsprev = ~VSPP;

    function automatic logic [7:0] pix(input logic de, input logic [1:0] m,
                                       input logic [18:0] a,
                                       input logic [7:0] hd, input logic [7:0] vd);
        if (!de) return 8'h00;
        case (m)
            2'd0:    return mem_f(a);
            2'd1:    return {{3{hd[7]}}, {3{hd[6]}}, {2{hd[5]}}};
            2'd2:    return 8'hE0;
            default: return (hd[4] ^ vd[4]) ? 8'hFF : 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: push expectations for the current inputs, then advance.
    task automatic step();
        exp_t e;
        if (rst) begin
            foreach (q1[i]) if (q1[i].due > edge_n) begin
                q1[i].de = 1'b0; q1[i].hs = ~HSPP; q1[i].vs = ~VSPP; q1[i].rgb = 8'h00;
            end
            foreach (q3[i]) if (q3[i].due > edge_n) begin
                q3[i].de = 1'b0; q3[i].hs = ~HSPP; q3[i].vs = ~VSPP; q3[i].rgb = 8'h00;
            end
            e.de = 1'b0; e.hs = ~HSPP; e.vs = ~VSPP; e.rgb = 8'h00;
            m_mode = 2'd0;
            m_fc = 16'd0;
            m_vsprev = ~VSPP;
        end else begin
            e.de  = de_in;
            e.hs  = hsync_in;
            e.vs  = vsync_in;
            e.rgb = pix(de_in, m_mode, addr_in, hdata_in[7:0], vdata_in[7:0]);
            if (vsync_in == VSPP && m_vsprev != VSPP) begin
                m_mode = mode_req;
                m_fc   = m_fc + 16'd1;
            end
            m_vsprev = vsync_in;
        end
        e.due = edge_n + 3;
        q1.push_back(e);
        e.due = edge_n + 5;
        q3.push_back(e);
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    always @(negedge clk) begin
        if (q1.size() > 0 && q1[0].due == edge_n) begin
            c1 = q1.pop_front();
            tests++;
            assert ({de1, hs1, vs1, red1, green1, blue1} === {c1.de, c1.hs, c1.vs, c1.rgb})
            else begin
                fails++;
                $error("FAIL sb_lat1 edge %0d observed de/hs/vs/rgb %b%b%b/%h expected %b%b%b/%h",
                       edge_n, de1, hs1, vs1, {red1, green1, blue1},
                       c1.de, c1.hs, c1.vs, c1.rgb);
            end
        end
        if (q3.size() > 0 && q3[0].due == edge_n) begin
            c3 = q3.pop_front();
            tests++;
            assert ({de3, hs3, vs3, red3, green3, blue3} === {c3.de, c3.hs, c3.vs, c3.rgb})
            else begin
                fails++;
                $error("FAIL sb_lat3 edge %0d observed de/hs/vs/rgb %b%b%b/%h expected %b%b%b/%h",
                       edge_n, de3, hs3, vs3, {red3, green3, blue3},
                       c3.de, c3.hs, c3.vs, c3.rgb);
            end
        end
    end

    task automatic pixel_run(input int n, input logic [18:0] base, input int hstep);
        for (int i = 0; i < n; i++) begin
            de_in    = 1'b1;
            addr_in  = base + 19'(i);
            hdata_in = 12'(i * hstep);
            step();
        end
        de_in = 1'b0;
    endtask

    task automatic chk_mode_fc(input string tag);
        chk({tag, "_d1"}, {46'd0, mode1, fc1}, {46'd0, m_mode, m_fc});
        chk({tag, "_d3"}, {46'd0, mode3, fc3}, {46'd0, m_mode, m_fc});
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step();
        step();
        chk("reset_d1", {21'd0, fb_addr1, red1, green1, blue1, de1, hs1, vs1, mode1, fc1},
            {21'd0, 19'd0, 8'd0, 1'b0, 1'b1, 1'b1, 2'd0, 16'd0});
        chk("reset_d3", {21'd0, fb_addr3, red3, green3, blue3, de3, hs3, vs3, mode3, fc3},
            {21'd0, 19'd0, 8'd0, 1'b0, 1'b1, 1'b1, 2'd0, 16'd0});
        rst = 1'b0;
        step();

        // Latency: one pixel at address 5
        de_in = 1'b1;
        addr_in = 19'd5;
        hdata_in = '0;
        step();
        chk("fb_addr_t1_d1", {45'd0, fb_addr1}, {45'd0, 19'd5});
        chk("fb_addr_t1_d3", {45'd0, fb_addr3}, {45'd0, 19'd5});
        de_in = 1'b0;
        addr_in = 19'd9;
        step();
        step();
        chk("lat_t3_d1", {55'd0, red1, green1, blue1, de1},
            {55'd0, 3'd7, 3'd0, 2'd3, 1'b1});

        // Blanking: address must hold while de_in is low
        for (int i = 0; i < 4; i++) step();
        chk("blank_hold_d1", {45'd0, fb_addr1}, {45'd0, 19'd5});
        chk("blank_hold_d3", {45'd0, fb_addr3}, {45'd0, 19'd5});
        chk("blank_rgb_d3", {55'd0, red3, green3, blue3, de3}, 64'd0);

        // Active line followed by a 96-cycle hsync pulse
        pixel_run(16, 19'd100, 16);
        hsync_in = 1'b0;
        for (int i = 0; i < 96; i++) step();
        hsync_in = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Mode request mid-frame has no effect
        mode_req = 2'd1;
        pixel_run(8, 19'd200, 32);
        chk("gate_mode_d1", {62'd0, mode1}, 64'd0);
        chk("gate_mode_d3", {62'd0, mode3}, 64'd0);

        // Frame boundary; held vsync counts once
        vsync_in = 1'b0;
        step();
        chk_mode_fc("edge1");
        chk("edge1_mode_d1", {62'd0, mode1}, 64'd1);
        step();
        step();
        chk_mode_fc("edge1_held");
        chk("edge1_held_fc_d3", {48'd0, fc3}, 64'd1);
        vsync_in = 1'b1;
        step();
        pixel_run(32, 19'd0, 8);
        for (int i = 0; i < 4; i++) step();

        // Request landing on the boundary cycle itself
        mode_req = 2'd2;
        vsync_in = 1'b0;
        step();
        chk_mode_fc("edge2");
        vsync_in = 1'b1;
        mode_req = 2'd0;
        step();
        pixel_run(8, 19'd300, 8);
        chk_mode_fc("edge2_after");

        // Checker pattern
        mode_req = 2'd3;
        vsync_in = 1'b0;
        step();
        vsync_in = 1'b1;
        step();
        chk_mode_fc("edge3");
        vdata_in = 12'd16;
        pixel_run(8, 19'd0, 16);
        vdata_in = 12'd0;
        pixel_run(8, 19'd0, 16);
        step();

        // Counter wrap
        force u_d1.frame_count_q = 16'hFFFF;
        force u_d3.frame_count_q = 16'hFFFF;
        #1;
        release u_d1.frame_count_q;
        release u_d3.frame_count_q;
        m_fc = 16'hFFFF;
        chk_mode_fc("preload");
        vsync_in = 1'b0;
        step();
        chk_mode_fc("wrap");
        chk("wrap_zero_d1", {48'd0, fc1}, 64'd0);
        step();
        step();
        chk_mode_fc("wrap_held");
        vsync_in = 1'b1;
        step();

        // Reset in the middle of an active run
        hsync_in = 1'b0;
        pixel_run(6, 19'd40, 16);
        de_in = 1'b1;
        rst = 1'b1;
        step();
        chk("rst_mid_d1", {40'd0, red1, green1, blue1, hs1, de1, mode1, fc1},
            {40'd0, 8'd0, 1'b1, 1'b0, 2'd0, 16'd0});
        chk("rst_mid_d3", {40'd0, red3, green3, blue3, hs3, de3, mode3, fc3},
            {40'd0, 8'd0, 1'b1, 1'b0, 2'd0, 16'd0});
        rst = 1'b0;
        hsync_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            addr_in = 19'(60 + k);
            hdata_in = 12'(k * 16);
            step();
            if (k < 2) chk("post_rst_de_d1", {63'd0, de1}, 64'd0);
            chk("post_rst_de_d3", {63'd0, de3}, 64'd0);
        end
        pixel_run(4, 19'd64, 16);
        for (int i = 0; i < 8; i++) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
